regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port register file for the CPU datapath. It has NREAD
//  combinational read ports, an ALU write port (A) and a load-return write
//  port (B). Optional write-to-read bypass and optional hardwired-zero r0.
//  A per-register busy scoreboard lets decode stall on operands whose load
//  is still outstanding. Sits between decode (read, issue) and writeback.
// PARAMETERS
//  DW       32  data width in bits
//  AW       3   address width; depth = 2**AW words
//  NREAD    2   number of read ports (1..4)
//  BYPASS   1   1: a read of an address being written this cycle returns the write data
//  ZERO_R0  0   1: r0 reads 0, ignores writes and is never busy
// PORTS
//  clk      in   1           rising-edge clock
//  n_rst    in   1           asynchronous reset, active low
//  ra       in   NREAD*AW    read addresses; port k = ra[k*AW +: AW]
//  rd       out  NREAD*DW    read data; port k = rd[k*DW +: DW]
//  rbusy    out  NREAD       busy bit of the register addressed by read port k
//  wa_a     in   AW          port A (ALU) write address
//  wd_a     in   DW          port A write data
//  we_a     in   1           port A write enable
//  wa_b     in   AW          port B (load return) write address
//  wd_b     in   DW          port B write data
//  we_b     in   1           port B write enable; also clears busy
//  iss_a    in   AW          issuing load destination address
//  iss_v    in   1           mark iss_a busy at the next edge
//  any_busy out  1           OR of all busy bits
// BEHAVIOUR
//  - Reset (n_rst=0, async): all words = 0 and all busy = 0 immediately;
//    rd = 0, rbusy = 0, any_busy = 0. Writes, issues and bypass are ignored
//    while reset is held. Deassertion mid-operation loses any pending writes.
//  - Writes: registered at posedge clk. If we_a and we_b target the same
//    address in one cycle, port A wins (younger instruction); B's data is dropped.
//  - Reads: combinational, zero-cycle latency.
//    BYPASS=0: rd returns the stored word; data written at edge N is visible after edge N.
//    BYPASS=1: rd returns wd_a if we_a and wa_a==ra, else wd_b if we_b and
//      wa_b==ra, else the stored word (same A>B priority as the write).
//  - ZERO_R0=1: address 0 always reads 0; rbusy = 0 for address 0; writes
//    and issues to r0 have no effect, and bypass never applies to r0.
//  - Scoreboard: busy[iss_a] is set at the edge when iss_v=1. busy[wa_b] is
//    cleared at the edge when we_b=1. Port A never changes busy.
//  - Set and clear of the same address in one cycle: busy stays 1 (new issue).
//  - Issuing to an already-busy address: busy stays 1 (no counting).
//  - rbusy[k] = busy[ra_k], taken from registered state and not bypassed.
//  - NREAD ports are independent; identical addresses on several ports are legal.
// TESTING
//  1. Reset: write 0xDEADBEEF to r3, pulse n_rst low asynchronously between edges
//     -> rd for r3 = 0 immediately, any_busy = 0.
//  2. Collision: we_a r5=0x11, we_b r5=0x22 in the same cycle -> r5 = 0x11 after
//     the edge; with BYPASS=1, rd(r5) = 0x11 during that cycle.
//  3. Bypass: BYPASS=1, r2 old value 0x5, we_b r2=0x7 -> rd(r2) = 0x7 in the same
//     cycle. BYPASS=0 -> 0x5 in that cycle, 0x7 after the edge.
//  4. Scoreboard: iss_v r4 -> rbusy = 1 and any_busy = 1 next cycle. we_b r4 =
//     0x99 -> busy clears after the edge. In the same cycle, iss_v r4 and
//     we_b r4 -> busy stays 1.
//  5. ZERO_R0=1: we_a r0=0xFFFF and iss_v r0 -> rd(r0) = 0, rbusy = 0, any_busy = 0.
//  6. NREAD=4: all four ports read r1=0xA5 while we_a writes r6 -> all ports
//     return 0xA5; a port reading r6 gets the bypassed value.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and load busy scoreboard
// Two write ports (A = ALU, B = load return, A wins on collision) and NREAD combinational reads.
module regfile_sb #(
  parameter int DW      = 32,
  parameter int AW      = 3,
  parameter int NREAD   = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NREAD*AW-1:0] ra,
  output logic [NREAD*DW-1:0] rd,
  output logic [NREAD-1:0]    rbusy,
  input  logic [AW-1:0]       wa_a,
  input  logic [DW-1:0]       wd_a,
  input  logic                we_a,
  input  logic [AW-1:0]       wa_b,
  input  logic [DW-1:0]       wd_b,
  input  logic                we_b,
  input  logic [AW-1:0]       iss_a,
  input  logic                iss_v,
  output logic                any_busy
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_a_ok;
  logic wr_b_ok;
  logic iss_ok;

  // r0 is inert when hardwired to zero: no write, no issue, no bypass.
  assign wr_a_ok = we_a && !((ZERO_R0 != 0) && (wa_a == '0));
  assign wr_b_ok = we_b && !((ZERO_R0 != 0) && (wa_b == '0));
  assign iss_ok  = iss_v && !((ZERO_R0 != 0) && (iss_a == '0));

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_b_ok) mem_d[wa_b] = wd_b;
    if (wr_a_ok) mem_d[wa_a] = wd_a;
    if (we_b)    busy_d[wa_b] = 1'b0;
    // A fresh issue overrides a same-cycle load return to that register.
    if (iss_ok)  busy_d[iss_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          is_zero;
    logic          byp_a;
    logic          byp_b;

    assign a       = ra[k*AW +: AW];
    assign is_zero = (ZERO_R0 != 0) && (a == '0);
    assign byp_a   = n_rst && (BYPASS != 0) && wr_a_ok && (wa_a == a);
    assign byp_b   = n_rst && (BYPASS != 0) && wr_b_ok && (wa_b == a);

    assign rd[k*DW +: DW] = is_zero ? '0 :
                            byp_a   ? wd_a :
                            byp_b   ? wd_b : mem_q[a];
    assign rbusy[k]       = is_zero ? 1'b0 : busy_q[a];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb across three parameter sets
// Instances: 0 = bypass, 1 = no bypass, 2 = four read ports with bypass and zero r0.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  rp [4];
  logic [2:0]  wa_a, wa_b, iss_a;
  logic [31:0] wd_a, wd_b;
  logic        we_a, we_b, iss_v;

  logic [5:0]   ra0, ra1;
  logic [11:0]  ra2;
  logic [63:0]  rd0, rd1;
  logic [127:0] rd2;
  logic [1:0]   rb0, rb1;
  logic [3:0]   rb2;
  logic         ab0, ab1, ab2;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          c;
    int          kind;
    int          k;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int cfg_nr  [3] = '{2, 2, 4};
  int cfg_byp [3] = '{1, 0, 1};
  int cfg_z   [3] = '{0, 0, 1};

  logic [31:0] mm [3][8];
  logic        bm [3][8];

  always #5 clk = ~clk;

  assign ra0 = {rp[1], rp[0]};
  assign ra1 = {rp[1], rp[0]};
  assign ra2 = {rp[3], rp[2], rp[1], rp[0]};

  regfile_sb #(.DW(32), .AW(3), .NREAD(2), .BYPASS(1), .ZERO_R0(0)) u_byp (
    .clk(clk), .n_rst(n_rst), .ra(ra0), .rd(rd0), .rbusy(rb0),
    .wa_a(wa_a), .wd_a(wd_a), .we_a(we_a), .wa_b(wa_b), .wd_b(wd_b), .we_b(we_b),
    .iss_a(iss_a), .iss_v(iss_v), .any_busy(ab0)
  );

  regfile_sb #(.DW(32), .AW(3), .NREAD(2), .BYPASS(0), .ZERO_R0(0)) u_nobyp (
    .clk(clk), .n_rst(n_rst), .ra(ra1), .rd(rd1), .rbusy(rb1),
    .wa_a(wa_a), .wd_a(wd_a), .we_a(we_a), .wa_b(wa_b), .wd_b(wd_b), .we_b(we_b),
    .iss_a(iss_a), .iss_v(iss_v), .any_busy(ab1)
  );

  regfile_sb #(.DW(32), .AW(3), .NREAD(4), .BYPASS(1), .ZERO_R0(1)) u_z4 (
    .clk(clk), .n_rst(n_rst), .ra(ra2), .rd(rd2), .rbusy(rb2),
    .wa_a(wa_a), .wd_a(wd_a), .we_a(we_a), .wa_b(wa_b), .wd_b(wd_b), .we_b(we_b),
    .iss_a(iss_a), .iss_v(iss_v), .any_busy(ab2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_rd(int c, logic [2:0] a);
    if (cfg_z[c] != 0 && a == 3'd0) return 32'h0;
    if (!n_rst) return 32'h0;
    if (cfg_byp[c] != 0 && we_a && wa_a == a) return wd_a;
    if (cfg_byp[c] != 0 && we_b && wa_b == a) return wd_b;
    return mm[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [2:0] a);
    if (cfg_z[c] != 0 && a == 3'd0) return 1'b0;
    return bm[c][a];
  endfunction

  function automatic logic exp_any(int c);
    logic r = 1'b0;
    for (int i = 0; i < 8; i++) r = r | bm[c][i];
    return r;
  endfunction

  function automatic logic [31:0] get_obs(int c, int kind, int k);
    case (c)
      0: return (kind == 0) ? rd0[k*32 +: 32] : (kind == 1) ? {31'h0, rb0[k]} : {31'h0, ab0};
      1: return (kind == 0) ? rd1[k*32 +: 32] : (kind == 1) ? {31'h0, rb1[k]} : {31'h0, ab1};
      default: return (kind == 0) ? rd2[k*32 +: 32] : (kind == 1) ? {31'h0, rb2[k]} : {31'h0, ab2};
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) begin
        mm[c][i] = 32'h0;
        bm[c][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (!n_rst) return;
    for (int c = 0; c < 3; c++) begin
      if (we_b && !(cfg_z[c] != 0 && wa_b == 3'd0)) mm[c][wa_b] = wd_b;
      if (we_a && !(cfg_z[c] != 0 && wa_a == 3'd0)) mm[c][wa_a] = wd_a;
      if (we_b) bm[c][wa_b] = 1'b0;
      if (iss_v && !(cfg_z[c] != 0 && iss_a == 3'd0)) bm[c][iss_a] = 1'b1;
    end
  endtask

  task automatic check_now();
    sb_t e;
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < cfg_nr[c]; k++) begin
        sb_q.push_back('{c, 0, k, exp_rd(c, rp[k])});
        sb_q.push_back('{c, 1, k, {31'h0, exp_busy(c, rp[k])}});
      end
      sb_q.push_back('{c, 2, 0, {31'h0, exp_any(c)}});
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("i%0d_%s%0d", e.c, (e.kind == 0) ? "rd" : (e.kind == 1) ? "rbusy" : "any", e.k),
            get_obs(e.c, e.kind, e.k), e.exp);
    end
  endtask

  task automatic cyc();
    check_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; iss_v = 1'b0;
  endtask

  task automatic set_rp(input logic [2:0] a0, a1, a2, a3);
    rp[0] = a0; rp[1] = a1; rp[2] = a2; rp[3] = a3;
  endtask

  initial begin
    idle();
    wa_a = 0; wa_b = 0; iss_a = 0; wd_a = 0; wd_b = 0;
    set_rp(0, 1, 2, 3);
    n_rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_now();
    n_rst = 1'b1;
    @(negedge clk);

    // async reset wipes a written word and busy bits mid-cycle
    we_a = 1; wa_a = 3; wd_a = 32'hDEADBEEF; iss_v = 1; iss_a = 4;
    set_rp(3, 4, 3, 4);
    cyc();
    idle();
    check_now();
    #1 n_rst = 1'b0;
    model_reset();
    check_now();
    we_a = 1; wa_a = 3; wd_a = 32'h1;
    cyc();
    n_rst = 1'b1;
    idle();
    cyc();

    // same-address collision, A wins
    we_a = 1; wa_a = 5; wd_a = 32'h11; we_b = 1; wa_b = 5; wd_b = 32'h22;
    set_rp(5, 5, 5, 0);
    cyc();
    idle();
    cyc();

    // bypass vs registered read
    we_a = 1; wa_a = 2; wd_a = 32'h5;
    cyc();
    idle();
    we_b = 1; wa_b = 2; wd_b = 32'h7;
    set_rp(2, 5, 2, 2);
    cyc();
    idle();
    cyc();

    // scoreboard set / clear / simultaneous
    iss_v = 1; iss_a = 4;
    set_rp(4, 2, 4, 4);
    cyc();
    idle();
    cyc();
    we_b = 1; wa_b = 4; wd_b = 32'h99;
    cyc();
    idle();
    cyc();
    iss_v = 1; iss_a = 4; we_b = 1; wa_b = 4; wd_b = 32'h3;
    cyc();
    idle();
    cyc();
    iss_v = 1; iss_a = 4;
    cyc();
    idle();
    we_b = 1; wa_b = 4; wd_b = 32'h4;
    cyc();
    idle();
    cyc();

    // r0 writes and issues
    we_a = 1; wa_a = 0; wd_a = 32'hFFFF; iss_v = 1; iss_a = 0;
    set_rp(0, 0, 0, 0);
    cyc();
    idle();
    cyc();
    we_b = 1; wa_b = 0; wd_b = 32'h0;
    cyc();
    idle();

    // four ports on r1 while r6 is written
    we_a = 1; wa_a = 1; wd_a = 32'hA5;
    cyc();
    we_a = 1; wa_a = 6; wd_a = 32'h66;
    set_rp(1, 1, 1, 1);
    check_now();
    set_rp(1, 1, 1, 6);
    cyc();
    idle();
    cyc();

    for (int n = 0; n < 200; n++) begin
      we_a = 1'($urandom_range(0, 1)); wa_a = 3'($urandom); wd_a = $urandom;
      we_b = 1'($urandom_range(0, 1)); wa_b = 3'($urandom); wd_b = $urandom;
      iss_v = 1'($urandom_range(0, 1)); iss_a = 3'($urandom);
      set_rp(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
